mips32_mc_control: RTL and testbench

Multi-cycle control sequencer for the MIPS32 datapath. It drives the control strobes of a shared-memory, multi-cycle datapath (PC, IR, register file, ALU, ALUOut), one state per datapath cycle. It stalls on a memory ready handshake, halts on illegal instructions and counts fetched instructions. It sits between the instruction register (opcode/funct) and the datapath muxes and enables.

---
 rtl/mips32_mc_control.sv | 221 ++++++++++++++++++++++
 tb/tb_mips32_mc_control.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mc_control.sv
// Multi-cycle control sequencer for a shared-memory MIPS32 datapath.
// All strobes are registered from the next state; only ir_write_o and pc_en_o
// are qualified combinationally by mem_ready_i / zero_i.
module mips32_mc_control #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        ior_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        reg_dest_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  oper_alu_o,
  output logic [1:0]  pc_source_o,
  output logic        pc_en_o,
  output logic        illegal_o,
  output logic [3:0]  state_o,
  output logic [31:0] inst_count_o
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StRwb    = 4'd8,
    StBranch = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJump   = 4'd12,
    StHalt   = 4'd15
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef struct packed {
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] oper_alu;
    logic [1:0] pc_source;
    logic       pc_write;  // unconditional PC update (FETCH, JUMP)
    logic       branch;    // PC update gated by zero_i
    logic       fetch;     // qualifies ir_write and FETCH-time pc_write
    logic       illegal;
  } ctrl_t;

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] inst_count_q;
  logic        funct_valid;
  logic [2:0]  funct_alu;

  // Map R-type funct to an ALU operation and flag unsupported functs.
  always_comb begin
    funct_valid = 1'b1;
    funct_alu   = AluAdd;
    unique case (funct_i)
      6'b100000: funct_alu = AluAdd;
      6'b100010: funct_alu = AluSub;
      6'b100100: funct_alu = AluAnd;
      6'b100101: funct_alu = AluOr;
      6'b101010: funct_alu = AluSlt;
      default:   funct_valid = 1'b0;
    endcase
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        if (opcode_i == OpLw || opcode_i == OpSw)         state_d = StMemAdr;
        else if (opcode_i == OpRType && funct_valid)      state_d = StExec;
        else if (opcode_i == OpBeq)                       state_d = StBranch;
        else if (opcode_i == OpAddi)                      state_d = StAddiEx;
        else if (opcode_i == OpJ)                         state_d = StJump;
        else if (ILLEGAL_HALT)                            state_d = StHalt;
        else                                              state_d = StFetch;
      end
      StMemAdr: state_d = (opcode_i == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready_i) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready_i) state_d = StFetch;
      StExec:   state_d = StRwb;
      StRwb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StJump:   state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  // Control word for the state being entered, so it is registered with the state.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      StFetch: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.oper_alu  = AluAdd;
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.fetch     = 1'b1;
      end
      StDecode: begin
        ctrl_d.alu_src_b = 2'b11;
        ctrl_d.oper_alu  = AluAdd;
      end
      StMemAdr, StAddiEx: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.oper_alu  = AluAdd;
      end
      StMemRd: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.ior_d    = 1'b1;
      end
      StMemWb: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.ior_d     = 1'b1;
      end
      StExec: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.oper_alu  = funct_alu;
      end
      StRwb: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dest  = 1'b1;
      end
      StBranch: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.oper_alu  = AluSub;
        ctrl_d.pc_source = 2'b01;
        ctrl_d.branch    = 1'b1;
      end
      StAddiWb: ctrl_d.reg_write = 1'b1;
      StJump: begin
        ctrl_d.pc_source = 2'b10;
        ctrl_d.pc_write  = 1'b1;
      end
      StHalt:  ctrl_d.illegal = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  // State and control-word registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Fetched-instruction counter; bumps on the same edge that loads IR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_count_q <= '0;
    end else if (ctrl_q.fetch && mem_ready_i) begin
      inst_count_q <= inst_count_q + 32'd1;
    end
  end

  assign ior_d_o      = ctrl_q.ior_d;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign ir_write_o   = ctrl_q.fetch & mem_ready_i;
  assign reg_dest_o   = ctrl_q.reg_dest;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign reg_write_o  = ctrl_q.reg_write;
  assign alu_src_a_o  = ctrl_q.alu_src_a;
  assign alu_src_b_o  = ctrl_q.alu_src_b;
  assign oper_alu_o   = ctrl_q.oper_alu;
  assign pc_source_o  = ctrl_q.pc_source;
  // FETCH-time PC write must wait for the memory; JUMP writes unconditionally.
  assign pc_en_o      = (ctrl_q.pc_write & (mem_ready_i | ~ctrl_q.fetch)) |
                        (ctrl_q.branch & zero_i);
  assign illegal_o    = ctrl_q.illegal;
  assign state_o      = state_q;
  assign inst_count_o = inst_count_q;

endmodule

// File: tb/tb_mips32_mc_control.sv
// Bench for mips32_mc_control: directed and random instruction streams checked
// against a per-instruction state-sequence model and a per-state strobe table.
module tb_mips32_mc_control;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode_i;
  logic [5:0]  funct_i;
  logic        zero_i;
  logic        mem_ready_i;

  logic        ior_d0, mem_read0, mem_write0, ir_write0, reg_dest0, mem_to_reg0;
  logic        reg_write0, alu_src_a0, pc_en0, illegal0;
  logic [1:0]  alu_src_b0, pc_source0;
  logic [2:0]  oper_alu0;
  logic [3:0]  state0;
  logic [31:0] count0;

  logic        ior_d1, mem_read1, mem_write1, ir_write1, reg_dest1, mem_to_reg1;
  logic        reg_write1, alu_src_a1, pc_en1, illegal1;
  logic [1:0]  alu_src_b1, pc_source1;
  logic [2:0]  oper_alu1;
  logic [3:0]  state1;
  logic [31:0] count1;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_cnt0 = '0;
  logic [31:0] model_cnt1 = '0;
  bit          chk1 = 1'b1;

  mips32_mc_control #(.ILLEGAL_HALT(1'b1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .ior_d_o(ior_d0),
    .mem_read_o(mem_read0), .mem_write_o(mem_write0), .ir_write_o(ir_write0),
    .reg_dest_o(reg_dest0), .mem_to_reg_o(mem_to_reg0), .reg_write_o(reg_write0),
    .alu_src_a_o(alu_src_a0), .alu_src_b_o(alu_src_b0), .oper_alu_o(oper_alu0),
    .pc_source_o(pc_source0), .pc_en_o(pc_en0), .illegal_o(illegal0),
    .state_o(state0), .inst_count_o(count0)
  );

  mips32_mc_control #(.ILLEGAL_HALT(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .ior_d_o(ior_d1),
    .mem_read_o(mem_read1), .mem_write_o(mem_write1), .ir_write_o(ir_write1),
    .reg_dest_o(reg_dest1), .mem_to_reg_o(mem_to_reg1), .reg_write_o(reg_write1),
    .alu_src_a_o(alu_src_a1), .alu_src_b_o(alu_src_b1), .oper_alu_o(oper_alu1),
    .pc_source_o(pc_source1), .pc_en_o(pc_en1), .illegal_o(illegal1),
    .state_o(state1), .inst_count_o(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int ClsR = 0, ClsLw = 1, ClsSw = 2, ClsBeq = 3, ClsAddi = 4, ClsJ = 5;

  function automatic logic [5:0] op_of(input int cls);
    case (cls)
      ClsLw:   return 6'b100011;
      ClsSw:   return 6'b101011;
      ClsBeq:  return 6'b000100;
      ClsAddi: return 6'b001000;
      ClsJ:    return 6'b000010;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] funct_pick(input int k);
    case (k)
      0:       return 6'b100000;
      1:       return 6'b100010;
      2:       return 6'b100100;
      3:       return 6'b100101;
      default: return 6'b101010;
    endcase
  endfunction

  function automatic logic [2:0] alu_for(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Strobe table: {IorD,MemRead,MemWrite,IRWrite,RegDest,MemToReg,RegWrite,
  // ALUSrcA,ALUSrcB,OperALU,PCSource,PCEn,Illegal}
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                           input logic z, input logic [5:0] fn);
    logic iord, mr, mw, irw, rd, m2r, rw, sa, pe, il;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {iord, mr, mw, irw, rd, m2r, rw, sa, pe, il} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    case (st)
      4'd1:  begin mr = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pe = rdy; end
      4'd2:  begin sb = 2'b11; alu = 3'b010; end
      4'd3:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
      4'd4:  begin mr = 1; iord = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mw = 1; iord = 1; end
      4'd7:  begin sa = 1; alu = alu_for(fn); end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin sa = 1; alu = 3'b110; ps = 2'b01; pe = z; end
      4'd10: begin sa = 1; sb = 2'b10; alu = 3'b010; end
      4'd11: rw = 1;
      4'd12: begin ps = 2'b10; pe = 1; end
      4'd15: il = 1;
      default: ;
    endcase
    return {iord, mr, mw, irw, rd, m2r, rw, sa, sb, alu, ps, pe, il};
  endfunction

  function automatic logic [16:0] got0();
    return {ior_d0, mem_read0, mem_write0, ir_write0, reg_dest0, mem_to_reg0, reg_write0,
            alu_src_a0, alu_src_b0, oper_alu0, pc_source0, pc_en0, illegal0};
  endfunction

  function automatic logic [16:0] got1();
    return {ior_d1, mem_read1, mem_write1, ir_write1, reg_dest1, mem_to_reg1, reg_write1,
            alu_src_a1, alu_src_b1, oper_alu1, pc_source1, pc_en1, illegal1};
  endfunction

  task automatic chk_cycle(input logic [3:0] st, input logic rdy, input logic z);
    logic [16:0] e;
    e = exp_ctrl(st, rdy, z, funct_i);
    checks++;
    assert (got0() === e) else begin
      errors++; $error("FAIL ctrl0 st=%0d: got %h want %h", st, got0(), e);
    end
    checks++;
    assert (state0 === st) else begin
      errors++; $error("FAIL state0: got %0d want %0d", state0, st);
    end
    checks++;
    assert (count0 === model_cnt0) else begin
      errors++; $error("FAIL count0: got %h want %h", count0, model_cnt0);
    end
    if (chk1) begin
      checks++;
      assert ({got1(), state1, count1} === {e, st, model_cnt1}) else begin
        errors++; $error("FAIL dut1 st=%0d: got %h/%0d/%h want %h/%0d/%h", st, got1(),
                         state1, count1, e, st, model_cnt1);
      end
    end
  endtask

  // Called at posedge+1; drives the cycle's inputs and checks at the negedge.
  task automatic step(input logic [3:0] st, input logic rdy, input logic z);
    mem_ready_i = rdy;
    zero_i      = z;
    @(negedge clk);
    chk_cycle(st, rdy, z);
    if (st == 4'd1 && rdy) begin
      model_cnt0++;
      model_cnt1++;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction from its first FETCH cycle to the edge back into FETCH.
  task automatic run_instr(input int cls, input logic [5:0] fn, input int wf,
                           input int wm, input logic z);
    opcode_i = op_of(cls);
    funct_i  = fn;
    for (int i = 0; i < wf; i++) step(4'd1, 1'b0, rb());
    step(4'd1, 1'b1, rb());
    step(4'd2, rb(), rb());
    case (cls)
      ClsLw: begin
        step(4'd3, rb(), rb());
        for (int i = 0; i < wm; i++) step(4'd4, 1'b0, rb());
        step(4'd4, 1'b1, rb());
        step(4'd5, rb(), rb());
      end
      ClsSw: begin
        step(4'd3, rb(), rb());
        for (int i = 0; i < wm; i++) step(4'd6, 1'b0, rb());
        step(4'd6, 1'b1, rb());
      end
      ClsBeq:  step(4'd9, rb(), z);
      ClsAddi: begin step(4'd10, rb(), rb()); step(4'd11, rb(), rb()); end
      ClsJ:    step(4'd12, rb(), rb());
      default: begin step(4'd7, rb(), rb()); step(4'd8, rb(), rb()); end
    endcase
  endtask

  // Checks the fully-reset output state with no clock edge required.
  task automatic reset_check(input string tag);
    checks++;
    assert ({got0(), state0, count0} === {17'd0, 4'd0, 32'd0}) else begin
      errors++; $error("FAIL %s: got %h/%0d/%h want 0/0/0", tag, got0(), state0, count0);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode_i = '0; funct_i = '0; zero_i = 0; mem_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_check("reset");
    rst_n = 1'b1;
    step(4'd0, rb(), rb());

    // Directed: R-type add, lw with 3 waits, beq taken/not taken, others.
    run_instr(ClsR, 6'b100000, 0, 0, 0);
    run_instr(ClsLw, 6'h00, 0, 3, 0);
    run_instr(ClsBeq, 6'h00, 0, 0, 1'b1);
    run_instr(ClsBeq, 6'h00, 0, 0, 1'b0);
    run_instr(ClsSw, 6'h00, 2, 1, 0);
    run_instr(ClsAddi, 6'h00, 1, 0, 0);
    run_instr(ClsJ, 6'h00, 0, 0, 0);
    for (int k = 1; k < 5; k++) run_instr(ClsR, funct_pick(k), 0, 0, 0);

    // Random instruction stream with random wait states.
    for (int n = 0; n < 60; n++) begin
      run_instr(int'($urandom_range(0, 5)), funct_pick(int'($urandom_range(0, 4))),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb());
    end

    // Counter wrap: preload the last value before 2^32.
    force dut0.inst_count_q = 32'hFFFF_FFFF;
    #1 release dut0.inst_count_q;
    model_cnt0 = 32'hFFFF_FFFF;
    run_instr(ClsJ, 6'h00, 0, 0, 0);
    run_instr(ClsR, 6'b100000, 0, 0, 0);

    // Asynchronous reset in the middle of a MEMWR wait.
    opcode_i = op_of(ClsSw);
    step(4'd1, 1'b1, rb());
    step(4'd2, rb(), rb());
    step(4'd3, rb(), rb());
    mem_ready_i = 1'b0;
    #1;
    checks++;
    assert (mem_write0 === 1'b1 && ior_d0 === 1'b1) else begin
      errors++; $error("FAIL memwr_wait: got %b%b want 11", mem_write0, ior_d0);
    end
    rst_n = 1'b0;
    #1;
    reset_check("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_cnt0 = '0;
    model_cnt1 = '0;
    step(4'd0, rb(), rb());
    run_instr(ClsLw, 6'h00, 1, 0, 0);

    // Illegal opcode: dut0 halts, dut1 returns to FETCH.
    opcode_i = 6'b111111;
    step(4'd1, 1'b1, rb());
    step(4'd2, rb(), rb());
    chk1 = 1'b0;
    mem_ready_i = 1'b1;
    @(negedge clk);
    chk_cycle(4'd15, 1'b1, zero_i);
    checks++;
    assert (state1 === 4'd1 && illegal1 === 1'b0) else begin
      errors++; $error("FAIL nohalt: got st=%0d ill=%b want st=1 ill=0", state1, illegal1);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) step(4'd15, rb(), rb());

    rst_n = 1'b0;
    #1;
    reset_check("halt_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk1 = 1'b1;
    model_cnt0 = '0;
    model_cnt1 = '0;
    step(4'd0, rb(), rb());
    run_instr(ClsAddi, 6'h00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
